aes_batch_scheduler: RTL

Parametrised successor to the fixed ten-core AES batch scheduler. Accepts plaintext or ciphertext as a stream of BUS_W-bit beats and distributes 128-bit blocks to N_CORES external AES cores. It then sequences the round-key address through the rounds and streams results back in load order. New behaviour:
- Partial batches, terminated by `sink_last`.
- Mode latched per batch.
- Back-to-back batches with no IDLE gap.
- Optional block statistics.

---
 rtl/aes_batch_scheduler.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_batch_scheduler.sv
// aes_batch_scheduler: streams BUS_W-bit beats into 128-bit blocks, loads up to
// N_CORES external AES cores, sequences round-key addresses, then drains the
// core results in load order. Optional block statistics: AES_SCHED_STATS_EN.
module aes_batch_scheduler #(
  parameter int unsigned N_CORES          = 10,
  parameter int unsigned BUS_W            = 32,
  parameter int unsigned ROUNDS           = 10,
  parameter int unsigned CYCLES_PER_ROUND = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic [127:0]             round_key,
  output logic [3:0]               round_key_addr,
  output logic [127:0]             core_key,
  output logic                     core_mode,
  output logic [127:0]             core_in_text,
  output logic [N_CORES-1:0]       core_wr_en,
  output logic                     core_start,
  input  logic [128*N_CORES-1:0]   core_out_text,
  input  logic                     sink_valid,
  output logic                     sink_ready,
  input  logic [BUS_W-1:0]         sink_data,
  input  logic                     sink_last,
  output logic                     source_valid,
  input  logic                     source_ready,
  output logic [BUS_W-1:0]         source_data,
  output logic                     source_last,
  output logic [31:0]              blocks_done
);

  localparam int unsigned BEATS  = 128 / BUS_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BLK_W  = $clog2(N_CORES + 1);
  localparam int unsigned CNT_W  = $clog2(CYCLES_PER_ROUND + 1);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               core_mode_q, core_mode_d;
  logic               sink_ready_q, sink_ready_d;
  logic [N_CORES-1:0] wr_en_q, wr_en_d;
  logic [127:0]       hold_q, hold_d;
  logic [127:0]       asm_q, asm_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic               final_q, final_d;
  logic               core_start_q, core_start_d;
  logic [CNT_W-1:0]   sub_q, sub_d;
  logic [3:0]         rnd_q, rnd_d;
  logic [3:0]         addr_q, addr_d;
  logic               src_valid_q, src_valid_d;
  logic               src_last_q, src_last_d;
  logic [BUS_W-1:0]   src_data_q, src_data_d;
  logic [BLK_W-1:0]   oj_q, oj_d;
  logic [BEAT_W-1:0]  ow_q, ow_d;
  logic               src_hs;

  // Word w of core j, MSB-first, from the flattened core result bus.
  function automatic logic [BUS_W-1:0] pick_word(input logic [128*N_CORES-1:0] bus,
                                                 input logic [BLK_W-1:0] j,
                                                 input logic [BEAT_W-1:0] w);
    int unsigned sh;
    sh = 128 * 32'(j) + 128 - BUS_W * (32'(w) + 1);
    return BUS_W'(bus >> sh);
  endfunction

  assign src_hs = src_valid_q & source_ready;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      core_mode_q  <= 1'b0;
      sink_ready_q <= 1'b0;
      wr_en_q      <= '0;
      hold_q       <= '0;
      asm_q        <= '0;
      beat_q       <= '0;
      blk_q        <= '0;
      final_q      <= 1'b0;
      core_start_q <= 1'b0;
      sub_q        <= '0;
      rnd_q        <= '0;
      addr_q       <= '0;
      src_valid_q  <= 1'b0;
      src_last_q   <= 1'b0;
      src_data_q   <= '0;
      oj_q         <= '0;
      ow_q         <= '0;
    end else begin
      state_q      <= state_d;
      core_mode_q  <= core_mode_d;
      sink_ready_q <= sink_ready_d;
      wr_en_q      <= wr_en_d;
      hold_q       <= hold_d;
      asm_q        <= asm_d;
      beat_q       <= beat_d;
      blk_q        <= blk_d;
      final_q      <= final_d;
      core_start_q <= core_start_d;
      sub_q        <= sub_d;
      rnd_q        <= rnd_d;
      addr_q       <= addr_d;
      src_valid_q  <= src_valid_d;
      src_last_q   <= src_last_d;
      src_data_q   <= src_data_d;
      oj_q         <= oj_d;
      ow_q         <= ow_d;
    end
  end

  // Next-state and next-output logic; a dropped start overrides everything.
  always_comb begin
    state_d      = state_q;
    core_mode_d  = core_mode_q;
    sink_ready_d = sink_ready_q;
    wr_en_d      = '0;
    hold_d       = hold_q;
    asm_d        = asm_q;
    beat_d       = beat_q;
    blk_d        = blk_q;
    final_d      = 1'b0;
    core_start_d = core_start_q;
    sub_d        = sub_q;
    rnd_d        = rnd_q;
    addr_d       = addr_q;
    src_valid_d  = src_valid_q;
    src_last_d   = src_last_q;
    src_data_d   = src_data_q;
    oj_d         = oj_q;
    ow_d         = ow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = LOAD;
          core_mode_d  = mode;
          sink_ready_d = 1'b1;
          beat_d       = '0;
          blk_d        = '0;
        end
      end
      LOAD: begin
        if (final_q) begin
          state_d      = EXEC;
          core_start_d = 1'b1;
          sub_d        = '0;
          rnd_d        = '0;
          addr_d       = core_mode_q ? 4'(ROUNDS) : 4'd0;
        end else if (sink_valid && sink_ready_q) begin
          asm_d = (asm_q << BUS_W) | 128'(sink_data);
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d  = '0;
            hold_d  = asm_d;
            wr_en_d = N_CORES'(1) << blk_q;
            blk_d   = blk_q + BLK_W'(1);
            if (sink_last || (blk_q == BLK_W'(N_CORES - 1))) begin
              final_d      = 1'b1;
              sink_ready_d = 1'b0;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      EXEC: begin
        if (sub_q == CNT_W'(CYCLES_PER_ROUND - 1)) begin
          sub_d = '0;
          if (rnd_q == 4'(ROUNDS)) begin
            state_d      = DRAIN;
            core_start_d = 1'b0;
            addr_d       = '0;
            src_valid_d  = 1'b1;
            oj_d         = '0;
            ow_d         = '0;
            src_data_d   = pick_word(core_out_text, '0, '0);
            src_last_d   = (blk_q == BLK_W'(1)) && (BEATS == 1);
          end else begin
            rnd_d  = rnd_q + 4'd1;
            addr_d = core_mode_q ? (4'(ROUNDS) - rnd_d) : rnd_d;
          end
        end else begin
          sub_d = sub_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (src_hs) begin
          if (src_last_q) begin
            src_valid_d = 1'b0;
            src_last_d  = 1'b0;
            if (start) begin
              state_d      = LOAD;
              core_mode_d  = mode;
              sink_ready_d = 1'b1;
              beat_d       = '0;
              blk_d        = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            if (ow_q == BEAT_W'(BEATS - 1)) begin
              ow_d = '0;
              oj_d = oj_q + BLK_W'(1);
            end else begin
              ow_d = ow_q + BEAT_W'(1);
            end
            src_data_d = pick_word(core_out_text, oj_d, ow_d);
            src_last_d = (oj_d == blk_q - BLK_W'(1)) && (ow_d == BEAT_W'(BEATS - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && !start) begin
      state_d      = IDLE;
      sink_ready_d = 1'b0;
      wr_en_d      = '0;
      final_d      = 1'b0;
      beat_d       = '0;
      blk_d        = '0;
      core_start_d = 1'b0;
      sub_d        = '0;
      rnd_d        = '0;
      addr_d       = '0;
      src_valid_d  = 1'b0;
      src_last_d   = 1'b0;
      oj_d         = '0;
      ow_d         = '0;
    end
  end

`ifdef AES_SCHED_STATS_EN
  logic [31:0] blocks_done_q;

  // Count drained blocks; survives abort, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blocks_done_q <= '0;
    end else if (src_hs && (ow_q == BEAT_W'(BEATS - 1))) begin
      blocks_done_q <= blocks_done_q + 32'd1;
    end
  end

  assign blocks_done = blocks_done_q;
`else
  assign blocks_done = 32'd0;
`endif

  assign round_key_addr = addr_q;
  assign core_key       = round_key;
  assign core_mode      = core_mode_q;
  assign core_in_text   = hold_q;
  assign core_wr_en     = wr_en_q;
  assign core_start     = core_start_q;
  assign sink_ready     = sink_ready_q;
  assign source_valid   = src_valid_q;
  assign source_data    = src_data_q;
  assign source_last    = src_last_q;

endmodule
